// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, drain FSM
// encodings and common ASCII characters.
package uart_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LOAD      = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   localparam byte_t CH_A  = 8'h41;
   localparam byte_t CH_B  = 8'h42;
   localparam byte_t CH_CR = 8'h0D;
   localparam byte_t CH_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with level-derived full/empty and a registered read port.
// push_i/pop_i are accepted requests; flush_i overrides both.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [BYTE_W-1:0] wr_data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic [BYTE_W-1:0] rd_data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   level_o
);

   byte_t           mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   byte_t           rd_data_q;

   // Pointer and occupancy update; pointers wrap naturally at AW bits.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
      full_d  = (level_d == (AW+1)'(DEPTH));
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         if (pop_i && !flush_i) rd_data_q <= mem_q[rd_ptr_q];
      end
   end

   // Storage needs no reset; occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = rd_data_q;
   assign full_o    = full_q;
   assign empty_o   = empty_q;
   assign level_o   = level_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer in front of the UART transmitter core: accepts pushes into a FIFO
// and drains it one byte per frame over the core's strobe/busy handshake.
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned AW        = 5,
   parameter int unsigned BUSY_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       level,
   output logic              overflow,
   output logic              uart_wr,
   output logic [BYTE_W-1:0] uart_dat,
   input  logic              uart_busy,
   output logic              tx_done
);

   localparam int unsigned CW = $clog2(BUSY_WAIT + 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          uart_wr_q, uart_wr_d;
   logic          tx_done_q, tx_done_d;
   logic          ovf_q, ovf_d;
   logic          pop_c;
   logic          push_c;
   logic          fifo_full;
   logic          fifo_empty;

   sync_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push_c),
      .wr_data_i (wr_data),
      .pop_i     (pop_c),
      .flush_i   (flush),
      .rd_data_o (uart_dat),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (level)
   );

   // Drain FSM; a flush in IDLE discards the head byte instead of launching it.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      uart_wr_d  = 1'b0;
      tx_done_d  = 1'b0;
      pop_c      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !uart_busy && !flush) begin
               pop_c     = 1'b1;
               uart_wr_d = 1'b1;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (uart_busy) begin
               state_d = ST_WAIT_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
               if (wait_cnt_q == CW'(BUSY_WAIT - 1)) state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!uart_busy) begin
               tx_done_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A pop in the same cycle frees a slot, so a push while full is accepted then.
   always_comb begin
      push_c = wr_en && !flush && (!fifo_full || pop_c);
      ovf_d  = ovf_q;
      if (flush) begin
         ovf_d = 1'b0;
      end else if (wr_en && fifo_full && !pop_c) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         uart_wr_q  <= 1'b0;
         tx_done_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         uart_wr_q  <= uart_wr_d;
         tx_done_q  <= tx_done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign full     = fifo_full;
   assign empty    = fifo_empty;
   assign overflow = ovf_q;
   assign uart_wr  = uart_wr_q;
   assign tx_done  = tx_done_q;

endmodule
